tdm_demux4: RTL and testbench

- Receive end of the 4:1 select path. Takes a time-division-multiplexed stream of WIDTH-bit beats and distributes consecutive beats to four lanes a, b, c, d, in slot order 0..3.
- Slot tracking uses an internal 2-bit slot counter, which plays the role of the mux sel.
- Lanes are registered and released together as one frame with a single-cycle out_valid strobe.
- Sits between a serial/TDM link and the four-lane datapath.

---
 rtl/tdm_demux4.sv | 132 +++++++++++++
 tb/tb_tdm_demux4.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Receive side of the 4:1 TDM link: spreads consecutive beats over lanes a..d and releases them as one frame.
// Optional TDM_SYNC_ERR_EN adds a resync pulse (sync_err) and a saturating resync counter (err_cnt).
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic             out_valid,
    output logic [1:0]       slot
`ifdef TDM_SYNC_ERR_EN
    ,
    output logic             sync_err,
    output logic [7:0]       err_cnt
`endif
);

    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] stage0_q, stage0_d;
    logic [WIDTH-1:0] stage1_q, stage1_d;
    logic [WIDTH-1:0] stage2_q, stage2_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       eff_slot;

    // frame_sync forces the beat into slot 0, dropping any partial frame in staging
    assign eff_slot = frame_sync ? 2'd0 : slot_q;

    always_comb begin
        slot_d      = slot_q;
        stage0_d    = stage0_q;
        stage1_d    = stage1_q;
        stage2_d    = stage2_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        out_valid_d = 1'b0;
        if (din_valid) begin
            case (eff_slot)
                2'd0: begin
                    stage0_d = din;
                    slot_d   = 2'd1;
                end
                2'd1: begin
                    stage1_d = din;
                    slot_d   = 2'd2;
                end
                2'd2: begin
                    stage2_d = din;
                    slot_d   = 2'd3;
                end
                default: begin
                    a_d         = stage0_q;
                    b_d         = stage1_q;
                    c_d         = stage2_q;
                    d_d         = din;
                    out_valid_d = 1'b1;
                    slot_d      = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            stage0_q    <= '0;
            stage1_q    <= '0;
            stage2_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            stage0_q    <= stage0_d;
            stage1_q    <= stage1_d;
            stage2_q    <= stage2_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign d         = d_q;
    assign out_valid = out_valid_q;
    assign slot      = slot_q;

`ifdef TDM_SYNC_ERR_EN
    logic       sync_err_q, sync_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       resync;

    // A sync mark landing mid-frame is a resync; the counter sticks at its maximum
    assign resync = din_valid && frame_sync && (slot_q != 2'd0);

    always_comb begin
        sync_err_d = resync;
        err_cnt_d  = err_cnt_q;
        if (resync && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            sync_err_q <= sync_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign sync_err = sync_err_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: a WIDTH=1 instance for the pattern sweep and a WIDTH=4 instance for the rest.
// Resync error checks are compiled in only when TDM_SYNC_ERR_EN is defined.
module tb_tdm_demux4;

    logic       clk;
    logic       rst_n;
    logic [0:0] din1;
    logic       v1, fs1;
    logic [3:0] din4;
    logic       v4, fs4;

    logic [0:0] a1, b1, c1, d1;
    logic       ov1;
    logic [1:0] slot1;
    logic [3:0] a4, b4, c4, d4;
    logic       ov4;
    logic [1:0] slot4;
`ifdef TDM_SYNC_ERR_EN
    logic       se1, se4;
    logic [7:0] ec1, ec4;
`endif

    int total = 0;
    int bad   = 0;

    tdm_demux4 #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(v1), .frame_sync(fs1),
        .a(a1), .b(b1), .c(c1), .d(d1), .out_valid(ov1), .slot(slot1)
`ifdef TDM_SYNC_ERR_EN
        , .sync_err(se1), .err_cnt(ec1)
`endif
    );

    tdm_demux4 #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .din(din4), .din_valid(v4), .frame_sync(fs4),
        .a(a4), .b(b4), .c(c4), .d(d4), .out_valid(ov4), .slot(slot4)
`ifdef TDM_SYNC_ERR_EN
        , .sync_err(se4), .err_cnt(ec4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic beat1(input logic val, input logic valid, input logic fs);
        din1 = val; v1 = valid; fs1 = fs;
        @(posedge clk); #1;
        v1 = 1'b0; fs1 = 1'b0;
    endtask

    task automatic beat4(input logic [3:0] val, input logic valid, input logic fs);
        din4 = val; v4 = valid; fs4 = fs;
        @(posedge clk); #1;
        v4 = 1'b0; fs4 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din1 = '0; v1 = 1'b0; fs1 = 1'b0;
        din4 = '0; v4 = 1'b0; fs4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({a4, b4, c4, d4} !== 16'h0000) begin
            bad++; $display("FAIL reset_lanes4 got=%h want=0000", {a4, b4, c4, d4});
        end
        total++;
        if ({ov4, slot4, ov1, slot1, a1, b1, c1, d1} !== 10'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0", {ov4, slot4, ov1, slot1, a1, b1, c1, d1});
        end
`ifdef TDM_SYNC_ERR_EN
        total++;
        if ({se4, ec4} !== 9'b0) begin
            bad++; $display("FAIL reset_err got=%h want=0", {se4, ec4});
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sweep();
        int pulses = 0;
        int errs   = 0;
        logic [3:0] pat;
        for (int p = 0; p < 16; p++) begin
            pat = 4'(p);
            for (int i = 0; i < 4; i++) begin
                beat1(pat[3-i], 1'b1, (i == 0));
                if (ov1 === 1'b1) pulses++;
                if (ov1 !== (i == 3)) errs++;
                if (slot1 !== 2'((i + 1) % 4)) errs++;
            end
            if ({a1, b1, c1, d1} !== pat) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL sweep_errors got=%0d want=0", errs);
        end
        total++;
        if (pulses !== 16) begin
            bad++; $display("FAIL sweep_pulses got=%0d want=16", pulses);
        end
        beat1(1'b0, 1'b0, 1'b0);
        total++;
        if ({ov1, a1, b1, c1, d1} !== 5'b0_1111) begin
            bad++; $display("FAIL sweep_idle got=%b want=01111", {ov1, a1, b1, c1, d1});
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 8; i++) begin
            beat4(4'(i + 1), 1'b1, 1'b0);
            total++;
            if (ov4 !== (i == 3 || i == 7)) begin
                bad++; $display("FAIL stream_ov beat=%0d got=%b want=%b", i + 1, ov4, (i == 3 || i == 7));
            end
            if (i == 3) begin
                total++;
                if ({a4, b4, c4, d4} !== 16'h1234) begin
                    bad++; $display("FAIL stream_frame1 got=%h want=1234", {a4, b4, c4, d4});
                end
            end
        end
        total++;
        if ({a4, b4, c4, d4} !== 16'h5678) begin
            bad++; $display("FAIL stream_frame2 got=%h want=5678", {a4, b4, c4, d4});
        end
        beat4(4'hF, 1'b0, 1'b1);
        total++;
        if ({ov4, slot4, a4, b4, c4, d4} !== {1'b0, 2'd0, 16'h5678}) begin
            bad++; $display("FAIL stream_hold got=%h want=05678", {ov4, slot4, a4, b4, c4, d4});
        end
    endtask

    task automatic test_gaps();
        logic [3:0] gv[7]   = '{4'hA, 4'h0, 4'hB, 4'h0, 4'h0, 4'hC, 4'hD};
        logic       gval[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0] gslot[7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
        int pulses = 0;
        for (int i = 0; i < 7; i++) begin
            beat4(gv[i], gval[i], 1'b0);
            if (ov4 === 1'b1) pulses++;
            total++;
            if (slot4 !== gslot[i]) begin
                bad++; $display("FAIL gaps_slot step=%0d got=%0d want=%0d", i, slot4, gslot[i]);
            end
        end
        total++;
        if (pulses !== 1 || ov4 !== 1'b1) begin
            bad++; $display("FAIL gaps_pulse got=%0d/%b want=1/1", pulses, ov4);
        end
        total++;
        if ({a4, b4, c4, d4} !== 16'hABCD) begin
            bad++; $display("FAIL gaps_frame got=%h want=abcd", {a4, b4, c4, d4});
        end
    endtask

    task automatic test_resync();
        logic [3:0] rv[6] = '{4'h1, 4'h2, 4'h9, 4'h8, 4'h7, 4'h6};
        int pulses = 0;
        int errs   = 0;
        for (int i = 0; i < 6; i++) begin
            beat4(rv[i], 1'b1, (i == 2));
            if (ov4 === 1'b1) pulses++;
            if (i == 2) begin
                total++;
                if (slot4 !== 2'd1) begin
                    bad++; $display("FAIL resync_slot got=%0d want=1", slot4);
                end
            end
`ifdef TDM_SYNC_ERR_EN
            if (se4 !== (i == 2)) errs++;
`endif
        end
        total++;
        if (pulses !== 1 || ov4 !== 1'b1) begin
            bad++; $display("FAIL resync_pulse got=%0d/%b want=1/1", pulses, ov4);
        end
        total++;
        if ({a4, b4, c4, d4} !== 16'h9876) begin
            bad++; $display("FAIL resync_frame got=%h want=9876", {a4, b4, c4, d4});
        end
`ifdef TDM_SYNC_ERR_EN
        total++;
        if (errs !== 0 || ec4 !== 8'd1) begin
            bad++; $display("FAIL resync_err got=%0d/%0d want=0/1", errs, ec4);
        end
`endif
    endtask

    task automatic test_reset_midframe();
        logic [3:0] rv[4] = '{4'h3, 4'h2, 4'h1, 4'h0};
        beat4(4'h1, 1'b1, 1'b1);
        beat4(4'h2, 1'b1, 1'b0);
        beat4(4'h3, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({a4, b4, c4, d4, ov4, slot4} !== 19'b0) begin
            bad++; $display("FAIL midreset_async got=%h want=0", {a4, b4, c4, d4, ov4, slot4});
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            beat4(rv[i], 1'b1, 1'b0);
        end
        total++;
        if ({ov4, a4, b4, c4, d4} !== {1'b1, 16'h3210}) begin
            bad++; $display("FAIL midreset_frame got=%h want=13210", {ov4, a4, b4, c4, d4});
        end
    endtask

`ifdef TDM_SYNC_ERR_EN
    task automatic test_err_saturation();
        beat4(4'h5, 1'b1, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            beat4(4'h5, 1'b1, 1'b1);
            if (i == 254) begin
                total++;
                if (ec4 !== 8'hFE) begin
                    bad++; $display("FAIL errcnt_254 got=%h want=fe", ec4);
                end
            end
        end
        total++;
        if (ec4 !== 8'hFF || se4 !== 1'b1) begin
            bad++; $display("FAIL errcnt_sat got=%h/%b want=ff/1", ec4, se4);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sweep();
        test_streaming();
        test_gaps();
        test_resync();
        test_reset_midframe();
`ifdef TDM_SYNC_ERR_EN
        test_err_saturation();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
